// File: rtl/gpio_irq_bank.sv
// GPIO bank: per-channel pad drive, input synchronizer, edge-triggered pending interrupts.
// Optional per-channel debounce filter is built in when GPIO_IRQ_DEBOUNCE_EN is defined.

module gpio_irq_lane #(
  parameter int SYNC_STAGES = 2
`ifdef GPIO_IRQ_DEBOUNCE_EN
  , parameter int DEB_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic rstn,
  input  logic pad_in,
  input  logic dir,
  input  logic out_val,
  input  logic irq_en,
  input  logic irq_pol,
  input  logic eoi,
  output logic pad_out,
  output logic pad_oe_n,
  output logic in_sync,
  output logic pending
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   prev_q;
  logic                   edge_det;

  always_ff @(posedge clk) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic [7:0] deb_cnt;
  logic       deb_q;

  // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      deb_cnt <= '0;
      deb_q   <= 1'b0;
    end else if (sync_out == deb_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == 8'(DEB_CYCLES - 1)) begin
      deb_cnt <= '0;
      deb_q   <= sync_out;
    end else begin
      deb_cnt <= deb_cnt + 8'd1;
    end
  end

  assign in_sync = deb_q;
`else
  assign in_sync = sync_out;
`endif

  assign edge_det = irq_pol ? (prev_q & ~in_sync) : (~prev_q & in_sync);

  // A qualifying edge beats a same-cycle eoi; mask/dir changes never clear pending.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev_q   <= 1'b0;
      pending  <= 1'b0;
      pad_out  <= 1'b0;
      pad_oe_n <= 1'b1;
    end else begin
      prev_q   <= in_sync;
      pending  <= (edge_det & irq_en & ~dir) | (pending & ~eoi);
      pad_out  <= dir & out_val;
      pad_oe_n <= ~dir;
    end
  end
endmodule

module gpio_irq_bank #(
  parameter int NCH         = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] pad_in,
  output logic [NCH-1:0] pad_out,
  output logic [NCH-1:0] pad_oe_n,
  input  logic [NCH-1:0] dir,
  input  logic [NCH-1:0] out_val,
  input  logic [NCH-1:0] irq_en,
  input  logic [NCH-1:0] irq_pol,
  input  logic [NCH-1:0] eoi,
  output logic [NCH-1:0] in_sync,
  output logic [NCH-1:0] irq,
  output logic           irq_valid,
  output logic [4:0]     irq_id
);
  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("NCH out of range 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range 2..4");
  end
  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("DEB_CYCLES out of range 1..255");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    gpio_irq_lane #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef GPIO_IRQ_DEBOUNCE_EN
      , .DEB_CYCLES(DEB_CYCLES)
`endif
    ) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .pad_in  (pad_in[i]),
      .dir     (dir[i]),
      .out_val (out_val[i]),
      .irq_en  (irq_en[i]),
      .irq_pol (irq_pol[i]),
      .eoi     (eoi[i]),
      .pad_out (pad_out[i]),
      .pad_oe_n(pad_oe_n[i]),
      .in_sync (in_sync[i]),
      .pending (irq[i])
    );
  end

  assign irq_valid = |irq;

  // Scan high to low so the lowest pending index is the last (winning) write.
  always_comb begin
    irq_id = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (irq[i]) irq_id = 5'(i);
    end
  end
endmodule

// File: tb/tb_gpio_irq_bank.sv
// Self-checking bench for gpio_irq_bank: directed vectors/sequences plus randomized
// traffic against a queue-based reference model evaluated every clock.
module tb_gpio_irq_bank;
  localparam int NCH = 16;
  localparam int S   = 2;
  localparam int DEB = 4;
`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int LAT = S + 1 + DEB;
`else
  localparam int LAT = S + 1;
`endif

  logic            clk = 1'b0;
  logic            rstn;
  logic [NCH-1:0]  pad_in, dir, out_val, irq_en, irq_pol, eoi;
  logic [NCH-1:0]  pad_out, pad_oe_n, in_sync, irq;
  logic            irq_valid;
  logic [4:0]      irq_id;

  gpio_irq_bank #(.NCH(NCH), .SYNC_STAGES(S), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rstn(rstn), .pad_in(pad_in), .pad_out(pad_out), .pad_oe_n(pad_oe_n),
    .dir(dir), .out_val(out_val), .irq_en(irq_en), .irq_pol(irq_pol), .eoi(eoi),
    .in_sync(in_sync), .irq(irq), .irq_valid(irq_valid), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pad history queue, sync-output history, and pending set.
  logic [NCH-1:0] q_sync[$];
  logic [NCH-1:0] so_hist[$];
  logic [NCH-1:0] m_in_sync, m_prev, m_pend, m_out, m_oe_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q_sync.delete();
    so_hist.delete();
    for (int k = 0; k < S; k++)   q_sync.push_back('0);
    for (int k = 0; k < DEB; k++) so_hist.push_back('0);
    m_in_sync = '0;
    m_prev    = '0;
    m_pend    = '0;
    m_out     = '0;
    m_oe_n    = '1;
  endfunction

  function automatic int exp_id();
    for (int i = 0; i < NCH; i++) if (m_pend[i]) return i;
    return 0;
  endfunction

  task automatic model_edge();
    logic [NCH-1:0] det, sync_old;
    if (!rstn) begin
      model_reset();
    end else begin
      det    = (m_in_sync & ~m_prev & ~irq_pol) | (~m_in_sync & m_prev & irq_pol);
      m_pend = (m_pend & ~eoi) | (det & irq_en & ~dir);
      m_prev = m_in_sync;
      m_out  = dir & out_val;
      m_oe_n = ~dir;
      sync_old = q_sync[S-1];
      q_sync.push_front(pad_in);
      void'(q_sync.pop_back());
`ifdef GPIO_IRQ_DEBOUNCE_EN
      so_hist.push_front(sync_old);
      void'(so_hist.pop_back());
      for (int b = 0; b < NCH; b++) begin
        bit all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) if (so_hist[k][b] == m_in_sync[b]) all_diff = 1'b0;
        if (all_diff) m_in_sync[b] = ~m_in_sync[b];
      end
`else
      m_in_sync = q_sync[S-1];
      if (sync_old === 'x) m_in_sync = q_sync[S-1];
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_pad_out",   32'(pad_out),   32'(m_out));
    chk("m_pad_oe_n",  32'(pad_oe_n),  32'(m_oe_n));
    chk("m_in_sync",   32'(in_sync),   32'(m_in_sync));
    chk("m_irq",       32'(irq),       32'(m_pend));
    chk("m_irq_valid", 32'(irq_valid), 32'(|m_pend));
    chk("m_irq_id",    32'(irq_id),    32'(exp_id()));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  typedef struct {
    logic [NCH-1:0] dir;
    logic [NCH-1:0] out_val;
    logic [NCH-1:0] exp_out;
    logic [NCH-1:0] exp_oe_n;
  } vec_t;
  vec_t vecs[5];

  initial begin
    bit seen;
    vecs[0] = '{16'h0080, 16'h0080, 16'h0080, 16'hFF7F};
    vecs[1] = '{16'hFFFF, 16'hA5A5, 16'hA5A5, 16'h0000};
    vecs[2] = '{16'h0F0F, 16'hFFFF, 16'h0F0F, 16'hF0F0};
    vecs[3] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[4] = '{16'h8001, 16'h0001, 16'h0001, 16'h7FFE};

    model_reset();
    rstn = 1'b0; pad_in = '0; dir = '0; out_val = '0; irq_en = '0; irq_pol = '0; eoi = '0;
    ticks(2);
    chk("rst_oe_n",  32'(pad_oe_n), 32'h0000FFFF);
    chk("rst_irq",   32'(irq),      32'h0);
    chk("rst_id",    32'(irq_id),   32'h0);
    chk("rst_valid", 32'(irq_valid), 32'h0);
    rstn = 1'b1;
    tick();

    // Output path: table of direction/level patterns.
    for (int v = 0; v < 5; v++) begin
      dir = vecs[v].dir; out_val = vecs[v].out_val;
      tick();
      chk("vec_pad_out",  32'(pad_out),  32'(vecs[v].exp_out));
      chk("vec_pad_oe_n", 32'(pad_oe_n), 32'(vecs[v].exp_oe_n));
    end
    dir = '0; out_val = '0;
    tick();

    // Rising edge on channel 3 lands exactly LAT cycles later.
    irq_en = 16'h0008; irq_pol = '0; pad_in[3] = 1'b1;
    ticks(LAT - 1);
    chk("rise3_early", 32'(irq[3]), 32'h0);
    tick();
    chk("rise3_irq",   32'(irq),       32'h0008);
    chk("rise3_valid", 32'(irq_valid), 32'h1);
    chk("rise3_id",    32'(irq_id),    32'd3);
    eoi = 16'h0008; tick(); eoi = '0;
    chk("eoi3_clear", 32'(irq), 32'h0);

    // Priority between channels 5 and 12.
    irq_en = 16'h1020; pad_in[5] = 1'b1; pad_in[12] = 1'b1;
    ticks(LAT);
    chk("prio_id5", 32'(irq_id), 32'd5);
    eoi = 16'h0020; tick(); eoi = '0;
    chk("prio_id12", 32'(irq_id), 32'd12);
    eoi = 16'h1000; tick(); eoi = '0;
    chk("prio_valid0", 32'(irq_valid), 32'h0);
    chk("prio_id0",    32'(irq_id),    32'h0);

    // Falling-edge channel 0; edge and eoi in the same cycle.
    irq_en = 16'h0001; irq_pol = 16'h0001; pad_in[0] = 1'b1;
    ticks(LAT + 1);
    chk("fall0_rise_ignored", 32'(irq[0]), 32'h0);
    pad_in[0] = 1'b0;
    ticks(LAT);
    chk("fall0_pend", 32'(irq[0]), 32'h1);
    pad_in[0] = 1'b1;
    ticks(LAT + 1);
    pad_in[0] = 1'b0;
    ticks(LAT - 1);
    eoi = 16'h0001; tick(); eoi = '0;
    chk("set_wins", 32'(irq[0]), 32'h1);
    tick();
    chk("set_wins_hold", 32'(irq[0]), 32'h1);
    eoi = 16'h0001; tick(); eoi = '0;
    chk("eoi0_clear", 32'(irq[0]), 32'h0);

    // Output channel and masked channel never pend.
    irq_pol = '0; dir = 16'h0080; out_val = 16'h0080; irq_en = 16'h0084;
    tick();
    chk("out7_oe_n", 32'(pad_oe_n[7]), 32'h0);
    chk("out7_val",  32'(pad_out[7]),  32'h1);
    pad_in[7] = 1'b1;
    ticks(LAT + 1);
    chk("out7_no_irq", 32'(irq[7]), 32'h0);
    irq_en = 16'h0080; pad_in[2] = 1'b1;
    ticks(LAT + 1);
    chk("mask2_no_irq", 32'(irq[2]), 32'h0);

    // Pending survives mask/direction changes; stray eoi is harmless.
    dir = '0; out_val = '0; irq_en = 16'h0200; pad_in[9] = 1'b1;
    ticks(LAT);
    chk("ch9_pend", 32'(irq), 32'h0200);
    irq_en = '0; dir = 16'h0200;
    ticks(3);
    chk("ch9_sticky", 32'(irq), 32'h0200);
    eoi = 16'h0004; tick(); eoi = '0;
    chk("stray_eoi", 32'(irq), 32'h0200);
    eoi = 16'h0200; tick(); eoi = '0;
    chk("ch9_clear", 32'(irq), 32'h0);
    dir = '0;

    // Mid-operation reset, then pads held high through release.
    pad_in = '0; irq_en = '0; rstn = 1'b0; tick(); rstn = 1'b1; tick();
    irq_en = 16'h8001; irq_pol = '0; pad_in = 16'h8001;
    ticks(LAT);
    chk("pre_rst_irq", 32'(irq), 32'h8001);
    rstn = 1'b0; tick();
    chk("rst_mid_irq",     32'(irq),       32'h0);
    chk("rst_mid_oe_n",    32'(pad_oe_n),  32'h0000FFFF);
    chk("rst_mid_in_sync", 32'(in_sync),   32'h0);
    chk("rst_mid_valid",   32'(irq_valid), 32'h0);
    rstn = 1'b1;
    ticks(LAT - 1);
    chk("rel_early", 32'(irq), 32'h0);
    tick();
    chk("rel_edge", 32'(irq), 32'h8001);

`ifdef GPIO_IRQ_DEBOUNCE_EN
    // Short glitch filtered; long pulse passes.
    pad_in = '0; irq_en = '0; rstn = 1'b0; tick(); rstn = 1'b1; tick();
    irq_en = 16'h0002; irq_pol = '0;
    seen = 1'b0;
    pad_in[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(); seen |= in_sync[1]; end
    pad_in[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(); seen |= in_sync[1]; end
    chk("deb_glitch_in_sync", 32'(seen), 32'h0);
    chk("deb_glitch_irq",     32'(irq[1]), 32'h0);
    seen = 1'b0;
    pad_in[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin tick(); seen |= in_sync[1]; end
    pad_in[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(); seen |= in_sync[1]; end
    chk("deb_pulse_in_sync", 32'(seen), 32'h1);
    chk("deb_pulse_irq",     32'(irq[1]), 32'h1);
`endif

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 600; c++) begin
      rstn   = ($urandom_range(0, 149) != 0);
      pad_in = pad_in ^ NCH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) dir     = NCH'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0)  out_val = NCH'($urandom);
      if ($urandom_range(0, 15) == 0) irq_en  = NCH'($urandom);
      if ($urandom_range(0, 31) == 0) irq_pol = NCH'($urandom);
      eoi = NCH'($urandom & $urandom & $urandom);
      tick();
    end
    eoi = '0; rstn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_irq_bank.md
GPIO_IRQ_BANK -- requirements
Module: gpio_irq_bank

Interface
REQ-001 Parameter NCH, default 16: number of GPIO channels, range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: input synchronizer depth, range 2..4.
REQ-003 Parameter DEB_CYCLES, default 4: debounce stability window in clocks, range 1..255; used only when GPIO_IRQ_DEBOUNCE_EN is defined.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 pad_in  in  NCH  raw FROM_PAD values from the pad cells; asynchronous to clk.
REQ-007 pad_out  out  NCH  TO_PAD values driven to the pad cells.
REQ-008 pad_oe_n  out  NCH  per-pad output enable, active-low.
REQ-009 dir  in  NCH  per-channel direction, 1 = output, 0 = input.
REQ-010 out_val  in  NCH  requested output levels.
REQ-011 irq_en  in  NCH  per-channel interrupt enable.
REQ-012 irq_pol  in  NCH  per-channel edge select, 0 = rising, 1 = falling.
REQ-013 eoi  in  NCH  end-of-interrupt, one-cycle pulse per channel; clears pending.
REQ-014 in_sync  out  NCH  synchronized (and, if enabled, debounced) input levels.
REQ-015 irq  out  NCH  per-channel pending flags.
REQ-016 irq_valid  out  1  OR of irq.
REQ-017 irq_id  out  5  index of the lowest-numbered pending channel; 0 when irq_valid = 0.

Function
REQ-018 pad_oe_n[i] SHALL equal ~dir[i], registered with 1-cycle latency.
REQ-019 pad_out[i] SHALL equal out_val[i] when dir[i] = 1, else 0, registered with 1-cycle latency.
REQ-020 Each pad_in bit SHALL pass through a SYNC_STAGES-deep flop chain; in_sync SHALL reflect a pad change exactly SYNC_STAGES cycles later.
REQ-021 An edge SHALL be detected by comparing in_sync with a 1-cycle-delayed copy: rising = prev 0 -> 1, falling = prev 1 -> 0, as selected by irq_pol[i].
REQ-022 pending[i] SHALL set on the cycle after a detected edge when irq_en[i] = 1 and dir[i] = 0; otherwise the edge SHALL be dropped.
REQ-023 pending[i] SHALL clear on the cycle after eoi[i] = 1.
REQ-024 An edge and eoi on the same channel in the same cycle: set SHALL win, and pending stays 1.
REQ-025 Deasserting irq_en[i] or setting dir[i] = 1 SHALL NOT clear an existing pending bit; only eoi clears it.
REQ-026 eoi on a non-pending channel SHALL have no effect.
REQ-027 Multiple edges before eoi SHALL collapse into one pending bit; there is no counting.
REQ-028 irq_valid and irq_id SHALL be combinational from pending; lowest index has priority; irq_id width is fixed at 5 for all NCH.
REQ-029 Total latency from a pad edge to irq = SYNC_STAGES + 1 cycles, with debounce disabled.

Reset
REQ-030 While rstn = 0 at a clk edge, the following SHALL all be 0: sync chain, prev copy, pending, pad_out, irq, in_sync, irq_valid, irq_id.
REQ-031 While rstn = 0 at a clk edge, pad_oe_n SHALL be all 1, so all pads are inputs.
REQ-032 Reset asserted mid-operation SHALL discard all pending interrupts and in-flight edges within one cycle.
REQ-033 A pad held high through reset release SHALL produce one rising edge after SYNC_STAGES + 1 cycles; it pends only if enabled at that cycle.

Configuration
REQ-034 When macro GPIO_IRQ_DEBOUNCE_EN is defined, each channel SHALL add an 8-bit counter after the synchronizer.
REQ-035 With the macro defined, in_sync[i] SHALL update only after the synchronized input differs from in_sync[i] for DEB_CYCLES consecutive cycles.
REQ-036 With the macro defined, any return to the current value SHALL reset the counter to 0; the counter SHALL reset to 0.
REQ-037 When GPIO_IRQ_DEBOUNCE_EN is undefined, no counters SHALL exist and in_sync SHALL be the synchronizer output.

Verification
REQ-038 Rising edge: pad_in[3] 0 -> 1, irq_en[3] = 1, irq_pol[3] = 0 -> irq[3] = 1 exactly 3 cycles later, irq_valid = 1, irq_id = 3.
REQ-039 Priority: pending on channels 5 and 12 -> irq_id = 5; eoi[5] pulse -> irq_id = 12 next cycle; eoi[12] -> irq_valid = 0, irq_id = 0.
REQ-040 Simultaneous: falling edge detected on channel 0 (irq_pol[0] = 1) in the same cycle as eoi[0] -> irq[0] remains 1.
REQ-041 Output and mask: dir[7] = 1, out_val[7] = 1 -> pad_oe_n[7] = 0, pad_out[7] = 1 after 1 cycle; a pad_in[7] edge leaves irq[7] = 0; irq_en[2] = 0 edge -> irq[2] = 0.
REQ-042 Reset mid-operation: irq = 16'h8001, rstn = 0 for 1 cycle -> irq = 0, pad_oe_n = 16'hFFFF.
REQ-043 Debounce, with GPIO_IRQ_DEBOUNCE_EN and DEB_CYCLES = 4: a 3-cycle glitch on pad_in[1] produces no in_sync change; a 6-cycle pulse changes in_sync[1] and sets irq[1].
